e_mdu: RTL
==========

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It is the producer of the HI/LO values that the E->M pipeline register latches and forwards for MFHI/MFLO.
- It accepts mult/div/mthi/mtlo operations from the E stage, models multi-cycle latency with a busy counter, and exposes HI/LO plus a busy flag.
- The D-stage hazard logic uses the busy flag to stall MD-class instructions.

Parameters:
- MULT_CYCLES, 5, cycles from MULT/MULTU acceptance to HI/LO commit (must be >=1).
- DIV_CYCLES, 10, cycles from DIV/DIVU acceptance to HI/LO commit (must be >=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_op  input  3  operation code; encodings are listed in the package.
- in_rs  input  32  operand A, already forwarded: dividend, multiplicand, or MTHI/MTLO source.
- in_rt  input  32  operand B: divisor or multiplier.
- out_hi  output  32  architectural HI register.
- out_lo  output  32  architectural LO register.
- out_busy  output  1  high when an operation is in flight or a mult/div is being accepted this cycle.

Behaviour:
- Reset (synchronous, active-high, clock clk): out_hi=0, out_lo=0, busy_q=0, cnt=0, and the pending result registers are 0.
  - Reset mid-operation aborts the operation. No commit occurs and out_busy is 0 in the next cycle.
- Op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6. Values 7 and above are treated as MD_NONE.
- State: IDLE (busy_q=0) and RUN (busy_q=1), with a down-counter cnt.
- IDLE, posedge with a MULT/MULTU/DIV/DIVU op:
  - Compute the result and latch it into pend_hi/pend_lo.
  - Set cnt to MULT_CYCLES or DIV_CYCLES, set busy_q=1, and go to RUN.
  - out_hi/out_lo are not yet changed.
- RUN: cnt decrements every cycle. On the edge where cnt==1: out_hi<=pend_hi, out_lo<=pend_lo, busy_q<=0, go to IDLE.
- Latency: an op sampled at edge T is visible on out_hi/out_lo after edge T+N (N = MULT_CYCLES or DIV_CYCLES). busy_q is high for exactly N cycles.
- out_busy = busy_q | (in_op is MULT/MULTU/DIV/DIVU). The combinational term covers the acceptance cycle.
- MTHI/MTLO in IDLE: out_hi or out_lo <= in_rs at the next edge, no busy.
- Any op while in RUN, including MTHI/MTLO, is ignored with no state change. The hazard unit guarantees this never happens; the bench flags it with an assertion.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 to a 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 to a 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide boundaries:
  - Divisor 0 (DIV or DIVU): the operation still runs DIV_CYCLES busy. At commit, out_hi/out_lo keep their old values.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Simultaneous events: reset has priority over commit and acceptance. A commit edge and a new op on the same edge cannot occur, because the new op is ignored in RUN. Back-to-back ops are accepted starting the cycle after busy_q drops.

Decomposition:
- Shared package/header (_const.v): MD_* op encodings, the MULT_CYCLES/DIV_CYCLES defaults, and the Special funct codes MULT_S, MULTU_S, DIV_S, DIVU_S, MTHI_S, MTLO_S used by the E-stage decoder that drives in_op.
- Sub-module md_calc: purely combinational. Takes op, rs, rt and returns {res_hi, res_lo, div_by_zero}. It isolates the arithmetic so it can be checked standalone.
- The e_mdu top holds the FSM, counter, pending registers and the architectural HI/LO registers.

Test Plan:
1. Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> out_busy=1 for 5 cycles plus the accept cycle; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. out_hi/out_lo stay 0 until edge T+5.
2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles. DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
3. Preload via MTHI 0x11111111 and MTLO 0x22222222 (each visible next cycle, no busy). Then DIVU rs=5, rt=0 -> busy 10 cycles; afterwards hi=0x11111111, lo=0x22222222 unchanged. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. During RUN of a DIV, drive MTLO 0xDEAD and MULT ops -> both ignored. The final hi/lo equal the DIV result and busy ends at exactly T+10.
5. Start DIV, assert reset at cnt=4 -> next cycle out_busy=0, hi=lo=0, and no later commit. Then MULT 6*7 -> lo=42, hi=0 after 5 cycles.
6. Back-to-back: MULT 2*3 issued on the first cycle after busy drops from a prior op -> accepted immediately. lo=6 exactly 5 cycles later.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op encodings,
// default latencies, FSM states and the Special funct codes the decoder maps onto in_op.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  localparam logic [5:0] MULT_S  = 6'h18;
  localparam logic [5:0] MULTU_S = 6'h19;
  localparam logic [5:0] DIV_S   = 6'h1a;
  localparam logic [5:0] DIVU_S  = 6'h1b;
  localparam logic [5:0] MTHI_S  = 6'h11;
  localparam logic [5:0] MTLO_S  = 6'h13;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_md_start(input logic [2:0] op);
    logic r;
    case (md_op_e'(op))
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_md_calc.sv
// Purely combinational multiply/divide arithmetic; results are only meaningful
// for MULT/MULTU/DIV/DIVU, zero otherwise.
module e_mdu_md_calc
  import e_mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_by_zero
);

  logic [63:0] w_prod;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing; a zero divisor is replaced by 1 and flagged.
  always_comb begin
    w_signed_div = (i_op == MD_DIV);
    w_a_neg      = w_signed_div & i_rs[31];
    w_b_neg      = w_signed_div & i_rt[31];
    w_a_mag      = w_a_neg ? (32'd0 - i_rs) : i_rs;
    w_b_mag      = w_b_neg ? (32'd0 - i_rt) : i_rt;
    w_b_div      = (i_rt == 32'd0) ? 32'd1 : w_b_mag;
    w_uq         = w_a_mag / w_b_div;
    w_ur         = w_a_mag % w_b_div;
  end

  // Result selection per op.
  always_comb begin
    o_res_hi      = 32'd0;
    o_res_lo      = 32'd0;
    o_div_by_zero = 1'b0;
    w_a64         = 64'd0;
    w_b64         = 64'd0;
    w_prod        = 64'd0;
    case (md_op_e'(i_op))
      MD_MULT: begin
        w_a64  = {{32{i_rs[31]}}, i_rs};
        w_b64  = {{32{i_rt[31]}}, i_rt};
        w_prod = w_a64 * w_b64;
        {o_res_hi, o_res_lo} = w_prod;
      end
      MD_MULTU: begin
        w_a64  = {32'd0, i_rs};
        w_b64  = {32'd0, i_rt};
        w_prod = w_a64 * w_b64;
        {o_res_hi, o_res_lo} = w_prod;
      end
      MD_DIV, MD_DIVU: begin
        o_div_by_zero = (i_rt == 32'd0);
        o_res_lo      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
        o_res_hi      = w_a_neg ? (32'd0 - w_ur) : w_ur;
      end
      default: begin
        o_res_hi      = 32'd0;
        o_res_lo      = 32'd0;
        o_div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: latches a result on acceptance and commits
// it to HI/LO after a fixed latency, holding busy meanwhile.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic        out_busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_dbz;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_dbz;

  e_mdu_md_calc u_md_calc (
    .i_op         (in_op),
    .i_rs         (in_rs),
    .i_rt         (in_rt),
    .o_res_hi     (w_res_hi),
    .o_res_lo     (w_res_lo),
    .o_div_by_zero(w_dbz)
  );

  // Accept/count/commit FSM; anything presented while running is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_pend_hi  <= 32'd0;
      r_pend_lo  <= 32'd0;
      r_pend_dbz <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (is_md_start(in_op)) begin
            r_pend_hi  <= w_res_hi;
            r_pend_lo  <= w_res_lo;
            r_pend_dbz <= w_dbz;
            r_cnt      <= is_mult(in_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_state    <= ST_RUN;
          end else if (in_op == MD_MTHI) begin
            r_hi <= in_rs;
          end else if (in_op == MD_MTLO) begin
            r_lo <= in_rs;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (r_cnt == CW'(1)) begin
            // A zero divisor still burns the full latency but leaves HI/LO intact.
            if (!r_pend_dbz) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign out_hi   = r_hi;
  assign out_lo   = r_lo;
  assign out_busy = (r_state == ST_RUN) | is_md_start(in_op);

endmodule
